// File: rtl/sipo_rx_pkg.sv
// Shared constants for the serial frame link.
// The serializer side imports the same values.
package sipo_rx_pkg;

    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_CRC  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [7:0] CRC8_POLY    = 8'h07;
    localparam logic [7:0] CRC8_INIT    = 8'h00;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // One serial CRC-8 step: non-reflected, one message bit per call.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din,
                                             input logic [7:0] poly);
        return {crc[6:0], 1'b0} ^ ((crc[7] ^ din) ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8, one bit per enabled cycle. Shared by the
// receiver (checking) and the serializer (generation).
module crc8_serial
    import sipo_rx_pkg::*;
#(
    parameter logic [7:0] POLY = CRC8_POLY,
    parameter logic [7:0] INIT = CRC8_INIT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_clr,
    input  logic       i_din,
    output logic [7:0] o_crc
);

    logic [7:0] r_crc;

    // Clear wins over enable so a restart never folds in a stale bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_crc <= INIT;
        end else if (i_clr) begin
            r_crc <= INIT;
        end else if (i_en) begin
            r_crc <= crc8_step(r_crc, i_din, POLY);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out frame receiver: sync hunt, data byte
// reassembly and CRC-8 check of each frame.
module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter logic [7:0]  SYNC   = SYNC_DEFAULT,
    parameter int unsigned NBYTES = 2,
    parameter logic [7:0]  POLY   = CRC8_POLY
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_si,
    input  logic       i_si_vld,
    input  logic       i_abort,
    output logic [7:0] o_po,
    output logic       o_po_vld,
    output logic       o_en_crc,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_crc_err
);

    logic [1:0] r_state;
    logic [7:0] r_sr;
    logic [7:0] r_rcrc;
    logic [2:0] r_bitcnt;
    logic [3:0] r_bytecnt;
    logic [7:0] r_po;
    logic       r_po_vld;
    logic       r_frame_done;
    logic       r_crc_err;

    logic [7:0] w_sr_nxt;
    logic [7:0] w_rcrc_nxt;
    logic       w_sync_hit;
    logic       w_last_bit;
    logic       w_last_byte;
    logic       w_crc_en;
    logic       w_crc_clr;
    logic [7:0] w_crc;

    assign w_sr_nxt    = {i_si, r_sr[7:1]};
    assign w_rcrc_nxt  = {i_si, r_rcrc[7:1]};
    assign w_sync_hit  = (w_sr_nxt == SYNC);
    assign w_last_bit  = (r_bitcnt == 3'd7);
    assign w_last_byte = (r_bytecnt == 4'(NBYTES - 1));

    assign w_crc_en  = (r_state == ST_DATA) && i_si_vld && !i_abort;
    assign w_crc_clr = i_abort || ((r_state == ST_HUNT) && i_si_vld && w_sync_hit);

    crc8_serial #(
        .POLY (POLY),
        .INIT (CRC8_INIT)
    ) u_crc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_crc_en),
        .i_clr   (w_crc_clr),
        .i_din   (i_si),
        .o_crc   (w_crc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_HUNT;
            r_sr         <= 8'h00;
            r_rcrc       <= 8'h00;
            r_bitcnt     <= 3'd0;
            r_bytecnt    <= 4'd0;
            r_po         <= 8'h00;
            r_po_vld     <= 1'b0;
            r_frame_done <= 1'b0;
            r_crc_err    <= 1'b0;
        end else begin
            r_po_vld     <= 1'b0;
            r_frame_done <= 1'b0;
            if (i_abort) begin
                r_state   <= ST_HUNT;
                r_sr      <= 8'h00;
                r_rcrc    <= 8'h00;
                r_bitcnt  <= 3'd0;
                r_bytecnt <= 4'd0;
            end else begin
                case (r_state)
                    ST_HUNT: begin
                        if (i_si_vld) begin
                            r_sr <= w_sr_nxt;
                            if (w_sync_hit) begin
                                r_state   <= ST_DATA;
                                r_bitcnt  <= 3'd0;
                                r_bytecnt <= 4'd0;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (i_si_vld) begin
                            r_sr     <= w_sr_nxt;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (w_last_bit) begin
                                r_po      <= w_sr_nxt;
                                r_po_vld  <= 1'b1;
                                r_bytecnt <= r_bytecnt + 4'd1;
                                if (w_last_byte) begin
                                    r_state <= ST_CRC;
                                end
                            end
                        end
                    end
                    ST_CRC: begin
                        if (i_si_vld) begin
                            r_rcrc   <= w_rcrc_nxt;
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (w_last_bit) begin
                                r_state      <= ST_DONE;
                                r_frame_done <= 1'b1;
                                r_crc_err    <= (w_rcrc_nxt != w_crc);
                            end
                        end
                    end
                    ST_DONE: begin
                        // Restart the hunt from a clean window; a bit arriving now still counts.
                        r_state   <= ST_HUNT;
                        r_sr      <= i_si_vld ? {i_si, 7'h00} : 8'h00;
                        r_bitcnt  <= 3'd0;
                        r_bytecnt <= 4'd0;
                    end
                    default: begin
                        r_state <= ST_HUNT;
                    end
                endcase
            end
        end
    end

    assign o_po         = r_po;
    assign o_po_vld     = r_po_vld;
    assign o_en_crc     = (r_state == ST_CRC);
    assign o_busy       = (r_state == ST_DATA) || (r_state == ST_CRC);
    assign o_frame_done = r_frame_done;
    assign o_crc_err    = r_crc_err;

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: fixed vectors, hand-written corner
// sequences and random frames against a frame-level reference model.
module tb_sipo_rx;
    import sipo_rx_pkg::*;

    localparam int NB = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       si = 1'b0;
    logic       si_vld = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] po;
    logic       po_vld, en_crc, busy, frame_done, crc_err;

    sipo_rx #(
        .SYNC   (8'hA5),
        .NBYTES (NB),
        .POLY   (8'h07)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_si         (si),
        .i_si_vld     (si_vld),
        .i_abort      (abort),
        .o_po         (po),
        .o_po_vld     (po_vld),
        .o_en_crc     (en_crc),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_crc_err    (crc_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] got_po[$];
    logic       got_err[$];
    int         encrc_cnt = 0;

    always @(negedge clk) begin
        if (po_vld) got_po.push_back(po);
        if (frame_done) got_err.push_back(crc_err);
        if (en_crc) encrc_cnt++;
    end

    bit         tx_bits[$];
    logic [7:0] exp_po[$];
    logic       exp_err[$];

    typedef struct {
        logic [7:0] pre;
        int         pre_n;
        logic [7:0] d0, d1, cb;
        int         gap;
        logic [7:0] e0, e1;
        logic       eerr;
        bit         chk_en;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_crc(input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0] crc = 8'h00;
        logic [7:0] msg[2];
        logic [7:0] rev;
        msg[0] = d0;
        msg[1] = d1;
        for (int j = 0; j < 2; j++) begin
            // Bytes go out LSB-first, so the polynomial sees them bit-reversed.
            for (int k = 0; k < 8; k++) rev[k] = msg[j][7-k];
            crc = crc ^ rev;
            for (int k = 0; k < 8; k++) crc = crc[7] ? ((crc << 1) ^ 8'h07) : (crc << 1);
        end
        return crc;
    endfunction

    task automatic push_bits(input logic [7:0] b, input int n);
        for (int k = 0; k < n; k++) tx_bits.push_back(b[k]);
    endtask

    task automatic push_frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] cb);
        push_bits(8'hA5, 8);
        push_bits(d0, 8);
        push_bits(d1, 8);
        push_bits(cb, 8);
    endtask

    // Frame-level model: sliding sync search over the bit stream, then fixed-size frames.
    task automatic run_model();
        logic [7:0] win = 8'h00;
        logic [7:0] data[$];
        logic [7:0] acc = 8'h00;
        bit hunting = 1'b1;
        int cnt = 0;
        exp_po.delete();
        exp_err.delete();
        foreach (tx_bits[i]) begin
            if (hunting) begin
                win = {tx_bits[i], win[7:1]};
                if (win == 8'hA5) begin
                    hunting = 1'b0;
                    cnt = 0;
                    data.delete();
                end
            end else begin
                acc[cnt % 8] = tx_bits[i];
                cnt++;
                if (cnt % 8 == 0) begin
                    if (cnt / 8 <= NB) begin
                        exp_po.push_back(acc);
                        data.push_back(acc);
                    end else begin
                        exp_err.push_back(acc != ref_crc(data[0], data[1]));
                        hunting = 1'b1;
                        win = 8'h00;
                    end
                end
            end
        end
    endtask

    task automatic drive(input int gap_mode, input bit flush);
        foreach (tx_bits[i]) begin
            @(negedge clk);
            si = tx_bits[i];
            si_vld = 1'b1;
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                @(negedge clk);
                si_vld = 1'b0;
                si = 1'($urandom);
            end
        end
        if (flush) begin
            @(negedge clk);
            si_vld = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic restart();
        @(negedge clk);
        abort = 1'b1;
        si_vld = 1'b1;
        si = 1'($urandom);
        @(negedge clk);
        abort = 1'b0;
        si_vld = 1'b0;
        repeat (2) @(negedge clk);
        got_po.delete();
        got_err.delete();
        encrc_cnt = 0;
        tx_bits.delete();
    endtask

    task automatic check_fixed(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                               input logic eerr, input bit chk_en);
        check({nm, "_npo"}, got_po.size(), 2);
        if (got_po.size() > 0) check({nm, "_po0"}, got_po[0], e0);
        if (got_po.size() > 1) check({nm, "_po1"}, got_po[1], e1);
        check({nm, "_nfd"}, got_err.size(), 1);
        if (got_err.size() > 0) check({nm, "_err"}, got_err[0], eerr);
        if (chk_en) check({nm, "_encrc"}, encrc_cnt, 8);
    endtask

    task automatic check_model(input string nm, input bit chk_en);
        check({nm, "_npo"}, got_po.size(), exp_po.size());
        for (int i = 0; i < exp_po.size() && i < got_po.size(); i++)
            check({nm, "_po"}, got_po[i], exp_po[i]);
        check({nm, "_nfd"}, got_err.size(), exp_err.size());
        for (int i = 0; i < exp_err.size() && i < got_err.size(); i++)
            check({nm, "_err"}, got_err[i], exp_err[i]);
        if (chk_en) check({nm, "_encrc"}, encrc_cnt, 8 * exp_err.size());
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{8'h00, 0, 8'h80, 8'h00, 8'h15, 0, 8'h80, 8'h00, 1'b0, 1'b1};
        vecs[1] = '{8'h00, 0, 8'h80, 8'h00, 8'h14, 0, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{8'h3C, 8, 8'h80, 8'h00, 8'h15, 1, 8'h80, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 0, 8'h00, 8'h00, 8'h00, 2, 8'h00, 8'h00, 1'b0, 1'b0};

        // Reset while idle
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_po", po, 8'h00);
        check("rst_po_vld", po_vld, 1'b0);
        check("rst_en_crc", en_crc, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_crc_err", crc_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[v]) begin
            restart();
            push_bits(vecs[v].pre, vecs[v].pre_n);
            push_frame(vecs[v].d0, vecs[v].d1, vecs[v].cb);
            drive(vecs[v].gap, 1'b1);
            check_fixed($sformatf("vec%0d", v), vecs[v].e0, vecs[v].e1, vecs[v].eerr,
                        vecs[v].chk_en);
        end

        // Abort after the first data byte
        restart();
        push_bits(8'hA5, 8);
        push_bits(8'h80, 8);
        drive(0, 1'b0);
        @(negedge clk);
        si_vld = 1'b0;
        check("abort_busy_before", busy, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy_after", busy, 1'b0);
        repeat (4) @(negedge clk);
        check("abort_npo", got_po.size(), 1);
        check("abort_nfd", got_err.size(), 0);
        got_po.delete();
        encrc_cnt = 0;
        tx_bits.delete();
        push_frame(8'h80, 8'h00, 8'h15);
        drive(0, 1'b1);
        check_fixed("post_abort", 8'h80, 8'h00, 1'b0, 1'b1);

        // Reset pulsed in the middle of the CRC byte
        restart();
        push_bits(8'hA5, 8);
        push_bits(8'h80, 8);
        push_bits(8'h00, 8);
        push_bits(8'h15, 3);
        drive(0, 1'b0);
        @(negedge clk);
        si_vld = 1'b0;
        check("midcrc_en_crc_before", en_crc, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midcrc_en_crc_after", en_crc, 1'b0);
        check("midcrc_busy_after", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midcrc_nfd", got_err.size(), 0);
        got_po.delete();
        encrc_cnt = 0;
        tx_bits.delete();
        push_frame(8'h80, 8'h00, 8'h15);
        drive(0, 1'b1);
        check_fixed("post_rst", 8'h80, 8'h00, 1'b0, 1'b1);

        // Back-to-back frames, no idle cycle between them
        restart();
        push_frame(8'h80, 8'h00, 8'h15);
        push_frame(8'h12, 8'h34, ref_crc(8'h12, 8'h34));
        run_model();
        drive(0, 1'b1);
        check("b2b_npo", got_po.size(), 4);
        check("b2b_nfd", got_err.size(), 2);
        check_model("b2b", 1'b1);

        // Random frames with noise prefix, occasional CRC corruption and gaps
        for (int r = 0; r < 30; r++) begin
            logic [7:0] d0, d1, cb;
            int gap;
            restart();
            push_bits(8'($urandom), $urandom_range(0, 8));
            push_bits(8'($urandom), $urandom_range(0, 4));
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            cb = ref_crc(d0, d1);
            if ($urandom_range(0, 1) == 1) cb = cb ^ (8'h01 << $urandom_range(0, 7));
            push_frame(d0, d1, cb);
            if ($urandom_range(0, 3) == 0) push_frame(8'($urandom), d0, ref_crc(8'($urandom), d0));
            gap = $urandom_range(0, 2);
            run_model();
            drive(gap, 1'b1);
            check_model($sformatf("rand%0d", r), gap == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
Serial-in/parallel-out frame receiver, the far end of the team's byte serializer link.
- Samples a one-bit LSB-first stream, hunts for a sync byte, then reassembles NBYTES data bytes followed by one CRC-8 byte.
- Checks the CRC and emits bytes with a valid strobe to the downstream byte consumer.
- Raises an en_crc window while the CRC byte is on the wire.

Parameters:
SYNC, 8'hA5, sync byte value, matched LSB-first.
NBYTES, 2, data bytes per frame (1..15).
POLY, 8'h07, CRC-8 polynomial. Init value is 8'h00, with no reflection and no final XOR.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
si  in  1  serial data bit
si_vld  in  1  qualifies si. A bit is consumed only in a cycle where si_vld=1.
abort  in  1  synchronous frame abort, returns the block to HUNT
po  out  8  assembled data byte
po_vld  out  1  one-cycle strobe, po valid
en_crc  out  1  high while the CRC byte's bits are being received
busy  out  1  high in DATA or CRC state
frame_done  out  1  one-cycle strobe at end of frame
crc_err  out  1  valid with frame_done. Holds its value until the next frame_done.

Behaviour:
- Reset: all outputs 0, shift register 8'h00, crc 8'h00, bit/byte counters 0, state HUNT.
- Reset asserted mid-frame clears everything at once. No partial byte or frame_done is emitted.
- Shift rule on every consumed bit: sr <= {si, sr[7:1]}. The first received bit lands in bit 0 after 8 shifts.
- FSM states: HUNT, DATA, CRC, DONE (2-bit encoding).
- HUNT:
  - Shifts on every valid bit.
  - When the post-shift value equals SYNC, goes to DATA with bitcnt=0, bytecnt=0, crc=0.
  - Sliding window: no byte alignment is needed before sync.
- DATA:
  - Each valid bit updates the CRC serially: fb = crc[7]^si; crc <= {crc[6:0],1'b0} ^ (fb ? POLY : 0).
  - On the 8th bit: po <= assembled byte, and po_vld pulses in the next cycle (1 cycle latency from the 8th sampled bit).
  - bytecnt increments on each completed byte. After byte NBYTES-1 completes, goes to CRC.
- CRC:
  - en_crc=1 for the whole state.
  - Bits are assembled LSB-first into rcrc. The CRC register is frozen.
  - On the 8th bit, goes to DONE.
- DONE (one cycle):
  - frame_done=1.
  - crc_err = (rcrc != crc).
  - en_crc=0.
  - Then returns to HUNT, with sr cleared to 8'h00 so the trailing CRC bits cannot false-match SYNC.
- Gaps: si_vld=0 stalls all counters and the FSM with no timeout. po_vld and frame_done still fire exactly once.
- abort:
  - In any state, goes to HUNT next cycle and clears counters, crc and sr.
  - No po_vld or frame_done is issued in that cycle.
  - abort has priority over a simultaneous si_vld.
- crc_err and po hold their values between strobes.
- bitcnt is 3 bits and wraps 7->0. bytecnt is 4 bits.

Decomposition:
- Shared package holds:
  - the state encoding constants (HUNT=0, DATA=1, CRC=2, DONE=3);
  - the CRC8_POLY and CRC8_INIT constants;
  - SYNC_DEFAULT, so the serializer side uses identical values.
- One natural sub-module, crc8_serial: a one-bit-per-cycle CRC with en, clr and din inputs and an 8-bit crc output. The serializer reuses it for generation.
- The FSM, shift register and counters stay in sipo_rx.

Test Plan:
1. Reset during idle: rst low for 2 cycles -> po=0, po_vld=0, en_crc=0, frame_done=0, crc_err=0, busy=0.
2. Good frame: bits LSB-first for A5, 80, 00, 15, si_vld continuous.
   - po_vld pulses carrying 0x80, then 0x00.
   - en_crc high for exactly 8 cycles.
   - frame_done pulses once with crc_err=0.
3. Bad CRC: same frame with CRC byte 0x14 -> the data bytes are still delivered and frame_done fires with crc_err=1.
4. Stalls and false sync: sync preceded by bits of 0x3C, and si_vld toggled 1/0 every cycle through the frame.
   - No output before sync; the sliding match catches A5.
   - Same po values and crc_err=0 as test 2, each strobe a single cycle.
5. Abort and reset mid-frame:
   - abort asserted after the first data byte -> busy=0 the next cycle and no frame_done. A following good frame is received correctly.
   - Repeat with rst pulsed low mid-CRC -> en_crc drops immediately.
6. Back-to-back: two good frames with no gap -> second sync detected, 2 frame_done pulses, 4 po_vld pulses, no spurious sync from CRC bits.
